// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes (also used by the control unit), FSM encoding
// and default datapath widths.
package alu_pkg;

  localparam int ALU_W   = 16;
  localparam int ALU_SHW = 4;

  localparam logic [4:0] OP_ADD = 5'h01;
  localparam logic [4:0] OP_SUB = 5'h02;
  localparam logic [4:0] OP_LSR = 5'h03;
  localparam logic [4:0] OP_LSL = 5'h04;
  localparam logic [4:0] OP_RSR = 5'h05;
  localparam logic [4:0] OP_RSL = 5'h06;
  localparam logic [4:0] OP_MUL = 5'h07;
  localparam logic [4:0] OP_DIV = 5'h08;
  localparam logic [4:0] OP_MOD = 5'h09;
  localparam logic [4:0] OP_AND = 5'h0A;
  localparam logic [4:0] OP_OR  = 5'h0B;
  localparam logic [4:0] OP_XOR = 5'h0C;
  localparam logic [4:0] OP_NOT = 5'h0D;
  localparam logic [4:0] OP_CMP = 5'h0E;
  localparam logic [4:0] OP_TST = 5'h0F;
  localparam logic [4:0] OP_INC = 5'h10;
  localparam logic [4:0] OP_DEC = 5'h11;
  localparam logic [4:0] OP_NOP = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_ITER,
    ST_DONE,
    ST_REARM
  } state_e;

  function automatic logic is_iter_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
// lo/hi present the result of the step being taken; they are final while done=1.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] lo,
  output logic [W-1:0] hi,
  output logic         done
);

  localparam int CW = $clog2(W);

  logic          busy_q;
  logic [CW-1:0] cnt_q;
  logic          mode_q;
  logic [W-1:0]  m_q, hi_q, lo_q;
  logic [W-1:0]  hi_d, lo_d;
  logic [W:0]    mac, shl, dif;

  // multiply keeps the product in {hi,lo}; divide keeps remainder in hi, quotient bits shift into lo
  always_comb begin
    mac = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shl = {hi_q, lo_q[W-1]};
    dif = shl - {1'b0, m_q};
    if (mode_q) begin
      if (!dif[W]) begin
        hi_d = dif[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b1};
      end else begin
        hi_d = shl[W-1:0];
        lo_d = {lo_q[W-2:0], 1'b0};
      end
    end else begin
      hi_d = mac[W:1];
      lo_d = {mac[0], lo_q[W-1:1]};
    end
  end

  assign lo   = lo_d;
  assign hi   = hi_d;
  assign done = busy_q && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      cnt_q  <= '0;
    end else if (busy_q) begin
      cnt_q <= cnt_q + CW'(1);
      if (done) busy_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      mode_q <= mode;
      m_q    <= mode ? b : a;
      hi_q   <= '0;
      lo_q   <= mode ? a : b;
    end else if (busy_q) begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU answering the control unit's bgn/rdy execute handshake;
// single-cycle ops resolve in EXEC, MUL/DIV/MOD iterate in seq_muldiv.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W   = ALU_W,
  parameter int SHW = ALU_SHW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bgn,
  input  logic [5:0]   opcode,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic [W-1:0] acc1,
  output logic [W-1:0] acc2,
  output logic         zero,
  output logic         negative,
  output logic         carry,
  output logic         overflow,
  output logic         rdy
);

  state_e       state_q, state_d;
  logic         armed_q, armed_d;
  logic [4:0]   op_in, op_q;
  logic [W-1:0] a_q, b_q;
  logic [W-1:0] acc1_q, acc2_q;
  logic         z_q, n_q, c_q, v_q;
  logic         cap, ld_ex, ld_md, md_start;
  logic         unused_imm;

  assign op_in      = opcode[5:1];
  assign unused_imm = opcode[0];

  logic [W-1:0]   md_lo, md_hi, md_acc1, md_acc2;
  logic           md_done;

  seq_muldiv #(.W(W)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .mode  (op_in != OP_MUL),
    .a     (A),
    .b     (B),
    .lo    (md_lo),
    .hi    (md_hi),
    .done  (md_done)
  );

  assign md_acc1 = (op_q == OP_MOD) ? md_hi : md_lo;
  assign md_acc2 = (op_q == OP_MOD) ? md_lo : md_hi;

  logic [SHW-1:0] sh_n;
  logic [W-1:0]   opb, ex_acc1, ex_acc2, ex_fsrc, ex_flag;
  logic [W:0]     ex_sum, ex_dif, ex_sr, ex_sl;
  logic           ex_c, ex_v, ex_upd, ex_alt;

  always_comb begin
    sh_n    = b_q[SHW-1:0];
    opb     = ((op_q == OP_INC) || (op_q == OP_DEC)) ? W'(1) : b_q;
    ex_sum  = {1'b0, a_q} + {1'b0, opb};
    ex_dif  = {1'b0, a_q} - {1'b0, opb};
    ex_sr   = {a_q, 1'b0} >> sh_n;
    ex_sl   = {1'b0, a_q} << sh_n;
    ex_acc1 = a_q;
    ex_acc2 = '0;
    ex_c    = 1'b0;
    ex_v    = 1'b0;
    ex_upd  = 1'b1;
    ex_alt  = 1'b0;
    ex_fsrc = ex_dif[W-1:0];
    case (op_q)
      OP_ADD, OP_INC: begin
        ex_acc1 = ex_sum[W-1:0];
        ex_c    = ex_sum[W];
        ex_v    = (a_q[W-1] == opb[W-1]) && (ex_sum[W-1] != a_q[W-1]);
      end
      OP_SUB, OP_DEC, OP_CMP: begin
        ex_acc1 = (op_q == OP_CMP) ? a_q : ex_dif[W-1:0];
        ex_alt  = (op_q == OP_CMP);
        ex_c    = ex_dif[W];
        ex_v    = (a_q[W-1] != opb[W-1]) && (ex_dif[W-1] != a_q[W-1]);
      end
      OP_LSR: begin
        ex_acc1 = ex_sr[W:1];
        ex_c    = ex_sr[0];
      end
      OP_LSL: begin
        ex_acc1 = ex_sl[W-1:0];
        ex_c    = ex_sl[W];
      end
      OP_RSR: begin
        ex_acc1 = (a_q >> sh_n) | (a_q << (W - int'(sh_n)));
        ex_c    = (sh_n != '0) && ex_acc1[W-1];
      end
      OP_RSL: begin
        ex_acc1 = (a_q << sh_n) | (a_q >> (W - int'(sh_n)));
        ex_c    = (sh_n != '0) && ex_acc1[0];
      end
      // MUL/DIV/MOD only reach EXEC with B == 0
      OP_MUL: ex_acc1 = '0;
      OP_DIV: begin
        ex_acc1 = '1;
        ex_acc2 = a_q;
        ex_v    = 1'b1;
      end
      OP_MOD: begin
        ex_acc1 = a_q;
        ex_acc2 = '1;
        ex_v    = 1'b1;
      end
      OP_AND: ex_acc1 = a_q & b_q;
      OP_OR:  ex_acc1 = a_q | b_q;
      OP_XOR: ex_acc1 = a_q ^ b_q;
      OP_NOT: ex_acc1 = ~a_q;
      OP_TST: begin
        ex_alt  = 1'b1;
        ex_fsrc = a_q & b_q;
      end
      default: ex_upd = 1'b0;
    endcase
    ex_flag = ex_alt ? ex_fsrc : ex_acc1;
  end

  always_comb begin
    state_d  = state_q;
    armed_d  = armed_q;
    cap      = 1'b0;
    ld_ex    = 1'b0;
    ld_md    = 1'b0;
    md_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bgn && armed_q) begin
          cap     = 1'b1;
          armed_d = 1'b0;
          if (is_iter_op(op_in) && (B != '0)) begin
            md_start = 1'b1;
            state_d  = ST_ITER;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        ld_ex   = 1'b1;
        state_d = ST_DONE;
      end
      ST_ITER: begin
        if (md_done) begin
          ld_md   = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bgn) begin
          state_d = ST_REARM;
        end else begin
          state_d = ST_IDLE;
          armed_d = 1'b1;
        end
      end
      ST_REARM: begin
        if (!bgn) begin
          state_d = ST_IDLE;
          armed_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (cap) begin
      op_q <= op_in;
      a_q  <= A;
      b_q  <= B;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc1_q <= '0;
      acc2_q <= '0;
      z_q    <= 1'b0;
      n_q    <= 1'b0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
    end else if (ld_ex && ex_upd) begin
      acc1_q <= ex_acc1;
      acc2_q <= ex_acc2;
      z_q    <= (ex_flag == '0);
      n_q    <= ex_flag[W-1];
      c_q    <= ex_c;
      v_q    <= ex_v;
    end else if (ld_md) begin
      acc1_q <= md_acc1;
      acc2_q <= md_acc2;
      z_q    <= (op_q == OP_MUL) ? ({md_hi, md_lo} == '0) : (md_acc1 == '0);
      n_q    <= md_acc1[W-1];
      c_q    <= (op_q == OP_MUL) && (md_hi != '0);
      v_q    <= (op_q == OP_MUL) && (md_hi != '0);
    end
  end

  assign acc1     = acc1_q;
  assign acc2     = acc2_q;
  assign zero     = z_q;
  assign negative = n_q;
  assign carry    = c_q;
  assign overflow = v_q;
  assign rdy      = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq against an arithmetic reference model.
module tb_alu_seq;

  localparam logic [4:0] T_ADD = 5'h01, T_SUB = 5'h02, T_LSR = 5'h03, T_LSL = 5'h04;
  localparam logic [4:0] T_RSR = 5'h05, T_RSL = 5'h06, T_MUL = 5'h07, T_DIV = 5'h08;
  localparam logic [4:0] T_MOD = 5'h09, T_AND = 5'h0A, T_OR  = 5'h0B, T_XOR = 5'h0C;
  localparam logic [4:0] T_NOT = 5'h0D, T_CMP = 5'h0E, T_TST = 5'h0F, T_INC = 5'h10;
  localparam logic [4:0] T_DEC = 5'h11, T_NOP = 5'h1F;

  logic        clk = 1'b0;
  logic        rst, bgn;
  logic [5:0]  opcode;
  logic [15:0] A, B, acc1, acc2;
  logic        zero, negative, carry, overflow, rdy;

  always #5 clk = ~clk;

  alu_seq #(.W(16), .SHW(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bgn      (bgn),
    .opcode   (opcode),
    .A        (A),
    .B        (B),
    .acc1     (acc1),
    .acc2     (acc2),
    .zero     (zero),
    .negative (negative),
    .carry    (carry),
    .overflow (overflow),
    .rdy      (rdy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] e_acc1 = '0, e_acc2 = '0;
  logic        e_z = 1'b0, e_n = 1'b0, e_c = 1'b0, e_v = 1'b0;
  int          e_lat;

  logic [4:0] pool [20] = '{T_ADD, T_SUB, T_LSR, T_LSL, T_RSR, T_RSL, T_MUL, T_DIV,
                            T_MOD, T_AND, T_OR, T_XOR, T_NOT, T_CMP, T_TST, T_INC,
                            T_DEC, T_NOP, 5'h14, 5'h00};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: results straight from the op definitions using wide integer arithmetic.
  task automatic model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    longint ai, bi, r, p;
    int sa, sb, sr, n;
    logic [15:0] r1, r2, fz;
    bit upd, c, v, use_fz;
    ai = a; bi = b; p = 0;
    sa = int'($signed(a)); sb = int'($signed(b));
    n = int'(b[3:0]);
    upd = 1; r1 = a; r2 = '0; c = 0; v = 0; use_fz = 0; fz = '0;
    e_lat = ((op == T_MUL || op == T_DIV || op == T_MOD) && b != 0) ? 16 : 1;
    case (op)
      T_ADD, T_INC: begin
        if (op == T_INC) begin bi = 1; sb = 1; end
        r = ai + bi; r1 = 16'(r); c = (r > 65535);
        sr = sa + sb; v = (sr > 32767) || (sr < -32768);
      end
      T_SUB, T_DEC, T_CMP: begin
        if (op == T_DEC) begin bi = 1; sb = 1; end
        r = ai - bi; c = (ai < bi);
        sr = sa - sb; v = (sr > 32767) || (sr < -32768);
        if (op == T_CMP) begin r1 = a; fz = 16'(r); use_fz = 1; end
        else r1 = 16'(r);
      end
      T_LSR: begin r1 = 16'(ai >> n); c = (n == 0) ? 0 : (((ai >> (n - 1)) & 1) == 1); end
      T_LSL: begin r1 = 16'(ai << n); c = (n == 0) ? 0 : (((ai >> (16 - n)) & 1) == 1); end
      T_RSR: begin
        r1 = 16'((ai >> n) | (ai << (16 - n)));
        c = (n == 0) ? 0 : (((ai >> (n - 1)) & 1) == 1);
      end
      T_RSL: begin
        r1 = 16'((ai << n) | (ai >> (16 - n)));
        c = (n == 0) ? 0 : (((ai >> (16 - n)) & 1) == 1);
      end
      T_MUL: begin p = ai * bi; r1 = 16'(p); r2 = 16'(p >> 16); c = (r2 != 0); v = c; end
      T_DIV: begin
        if (b == 0) begin r1 = 16'hFFFF; r2 = a; v = 1; end
        else begin r1 = 16'(ai / bi); r2 = 16'(ai % bi); end
      end
      T_MOD: begin
        if (b == 0) begin r1 = a; r2 = 16'hFFFF; v = 1; end
        else begin r1 = 16'(ai % bi); r2 = 16'(ai / bi); end
      end
      T_AND: r1 = a & b;
      T_OR:  r1 = a | b;
      T_XOR: r1 = a ^ b;
      T_NOT: r1 = ~a;
      T_TST: begin fz = a & b; use_fz = 1; end
      default: upd = 0;
    endcase
    if (upd) begin
      e_acc1 = r1; e_acc2 = r2; e_c = c; e_v = v;
      if (use_fz) begin e_z = (fz == 0); e_n = fz[15]; end
      else begin e_z = (r1 == 0); e_n = r1[15]; end
      if (op == T_MUL) e_z = (p == 0);
    end
  endtask

  task automatic run_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit scramble, input int hold);
    int cyc;
    bit got;
    model(op, a, b);
    opcode = {op, 1'($urandom)};
    A = a; B = b; bgn = 1'b1;
    cyc = 0; got = 0;
    while (!got && cyc < 40) begin
      tick();
      cyc++;
      if (rdy) got = 1;
      else if (scramble) begin
        A = 16'($urandom); B = 16'($urandom); opcode = 6'($urandom);
      end
    end
    chk("rdy_seen", 32'(got), 1);
    if (got) chk("latency", 32'(cyc - 1), 32'(e_lat));
    chk("acc1", 32'(acc1), 32'(e_acc1));
    chk("acc2", 32'(acc2), 32'(e_acc2));
    chk("flags_zncv", 32'({zero, negative, carry, overflow}), 32'({e_z, e_n, e_c, e_v}));
    for (int k = 0; k < hold; k++) begin
      tick();
      chk("rdy_held_bgn", 32'(rdy), 0);
    end
    bgn = 1'b0;
    tick();
    chk("rdy_after_drop", 32'(rdy), 0);
  endtask

  initial begin
    bit seen;
    logic [4:0] op;
    logic [15:0] a, b;

    rst = 1'b1; bgn = 1'b0; opcode = '0; A = '0; B = '0;
    repeat (3) tick();
    chk("rst_rdy", 32'(rdy), 0);
    chk("rst_acc1", 32'(acc1), 0);
    chk("rst_acc2", 32'(acc2), 0);
    chk("rst_flags", 32'({zero, negative, carry, overflow}), 0);
    rst = 1'b0;
    tick();

    run_op(T_ADD, 16'h7FFF, 16'h0001, 0, 0);
    chk("add_acc1_lit", 32'(acc1), 32'h8000);
    chk("add_flags_lit", 32'({zero, negative, carry, overflow}), 32'b0101);
    run_op(T_MUL, 16'h1234, 16'h0100, 1, 0);
    chk("mul_acc1_lit", 32'(acc1), 32'h3400);
    chk("mul_acc2_lit", 32'(acc2), 32'h0012);
    run_op(T_DIV, 16'd100, 16'd7, 0, 0);
    chk("div_lit", 32'({acc1, acc2}), {16'd14, 16'd2});
    run_op(T_MOD, 16'd100, 16'd7, 1, 0);
    chk("mod_lit", 32'({acc1, acc2}), {16'd2, 16'd14});
    run_op(T_DIV, 16'h0042, 16'h0000, 0, 0);
    chk("div0_lit", 32'({acc1, acc2}), 32'hFFFF0042);
    run_op(T_CMP, 16'd5, 16'd5, 0, 0);
    run_op(T_NOP, 16'hBEEF, 16'h1234, 0, 0);
    chk("nop_keep_lit", 32'({acc1, zero, carry}), {16'd0, 16'd5, 1'b1, 1'b0});
    run_op(T_RSL, 16'h8001, 16'h0001, 0, 0);
    run_op(T_LSR, 16'h0003, 16'h0000, 0, 0);
    run_op(T_SUB, 16'h0001, 16'h0002, 0, 0);
    run_op(T_XOR, 16'hA5A5, 16'h0FF0, 0, 5);
    run_op(T_MUL, 16'hFFFF, 16'hFFFF, 0, 2);

    // abort an iterating multiply with reset
    model(T_MUL, 16'h4321, 16'h00FF);
    opcode = {T_MUL, 1'b0}; A = 16'h4321; B = 16'h00FF; bgn = 1'b1;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bgn = 1'b0;
    e_acc1 = '0; e_acc2 = '0; e_z = 0; e_n = 0; e_c = 0; e_v = 0;
    chk("abort_rdy", 32'(rdy), 0);
    chk("abort_acc", 32'({acc1, acc2}), 0);
    chk("abort_flags", 32'({zero, negative, carry, overflow}), 0);
    seen = 0;
    repeat (20) begin
      tick();
      seen |= rdy;
    end
    chk("abort_no_rdy", 32'(seen), 0);
    run_op(T_INC, 16'hFFFF, 16'h0000, 0, 0);

    for (int i = 0; i < 150; i++) begin
      op = pool[$urandom_range(0, 19)];
      a = 16'($urandom);
      b = 16'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = 16'($urandom_range(0, 17));
      run_op(op, a, b, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
